valrdy_repeater: RTL

VALRDY_REPEATER -- requirements
Module: valrdy_repeater

---
 rtl/valrdy_repeater.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/valrdy_repeater.sv
// valrdy_repeater: a chain of STAGES elastic register stages carrying a
// valid/ready stream. Each stage is a two-entry skid buffer (main + skid
// register), so every handshake signal at a stage boundary is registered
// while full throughput is kept.
//
// Parameters:
//   DATA_WIDTH  payload width in bits
//   STAGES      number of elastic stages (1..8); empty-pipe latency is STAGES
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; clears all valid/skid flags
//   in_val   upstream valid
//   in_dat   upstream payload
//   in_rdy   repeater can accept (flop output)
//   out_val  downstream valid (flop output)
//   out_dat  downstream payload (flop outputs)
//   out_rdy  downstream can accept
//
// Optional build macro VALRDY_REPEATER_CNT_EN adds:
//   in_cnt   32-bit count of input transfers (wraps)
//   out_cnt  32-bit count of output transfers (wraps)
module valrdy_repeater #(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  in_rdy,
  output logic                  out_val,
  output logic [DATA_WIDTH-1:0] out_dat,
  input  logic                  out_rdy
`ifdef VALRDY_REPEATER_CNT_EN
  ,
  output logic [31:0]           in_cnt,
  output logic [31:0]           out_cnt
`endif
);

  // Per-stage state
  logic [STAGES-1:0]     main_v;
  logic [STAGES-1:0]     skid_v;
  logic [STAGES-1:0]     rdy_q;
  logic [DATA_WIDTH-1:0] main_d [STAGES];
  logic [DATA_WIDTH-1:0] skid_d [STAGES];

  // Next-state values
  logic [STAGES-1:0]     main_v_n;
  logic [STAGES-1:0]     skid_v_n;
  logic [DATA_WIDTH-1:0] main_d_n [STAGES];
  logic [DATA_WIDTH-1:0] skid_d_n [STAGES];

  // Inter-stage wiring: entry i feeds stage i (upstream side), entry i+1 of
  // the ready chain is what stage i sees from downstream.
  logic [STAGES:0]       chain_v;
  logic [STAGES:0]       rdy_chain;
  logic [DATA_WIDTH-1:0] chain_d [STAGES+1];

  logic [STAGES-1:0]     up_fire;
  logic [STAGES-1:0]     dn_fire;

  always_comb begin
    chain_v    = {main_v, in_val};
    rdy_chain  = {out_rdy, rdy_q};
    chain_d[0] = in_dat;
    for (int unsigned i = 0; i < STAGES; i++) begin
      chain_d[i+1] = main_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      up_fire[i]  = chain_v[i] & rdy_q[i];
      dn_fire[i]  = main_v[i] & rdy_chain[i+1];
      main_v_n[i] = main_v[i];
      main_d_n[i] = main_d[i];
      skid_v_n[i] = skid_v[i];
      skid_d_n[i] = skid_d[i];
      if (!main_v[i] || dn_fire[i]) begin
        // Main is free this edge: the skid word is older, so it goes first.
        if (skid_v[i]) begin
          main_v_n[i] = 1'b1;
          main_d_n[i] = skid_d[i];
          skid_v_n[i] = 1'b0;
        end else if (up_fire[i]) begin
          main_v_n[i] = 1'b1;
          main_d_n[i] = chain_d[i];
        end else begin
          main_v_n[i] = 1'b0;
        end
      end else if (up_fire[i]) begin
        // Main is stalled; ready was still high, so park the arrival in skid.
        // rdy_q is low whenever skid is occupied, so skid is never overwritten.
        skid_v_n[i] = 1'b1;
        skid_d_n[i] = chain_d[i];
      end
    end
  end

  // Control flops. Ready is kept as its own flop (rather than ~skid_v) so it
  // can be held low during reset while skid_v is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= '0;
      skid_v <= '0;
      rdy_q  <= '0;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      rdy_q  <= ~skid_v_n;
    end
  end

  // Payload flops carry no reset; their contents are qualified by the flags.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      main_d[i] <= main_d_n[i];
      skid_d[i] <= skid_d_n[i];
    end
  end

  assign in_rdy  = rdy_q[0];
  assign out_val = main_v[STAGES-1];
  assign out_dat = main_d[STAGES-1];

`ifdef VALRDY_REPEATER_CNT_EN
  logic [31:0] in_cnt_q;
  logic [31:0] out_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (up_fire[0])        in_cnt_q  <= in_cnt_q + 32'd1;
      if (dn_fire[STAGES-1]) out_cnt_q <= out_cnt_q + 32'd1;
    end
  end

  assign in_cnt  = in_cnt_q;
  assign out_cnt = out_cnt_q;
`endif

endmodule
